// File: rtl/sprite_sched_pkg.sv
// Shared types and constants for the tear-free sprite update scheduler.
package sprite_sched_pkg;

  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;

  localparam logic [1:0] WR_NONE = 2'b11;
  localparam logic [1:0] WR_16   = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    DRAIN = 2'b01,
    DONE  = 2'b10
  } sched_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sprite_cmd_t;

  localparam int ENTRY_W = $bits(sprite_cmd_t);

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Synchronous command FIFO holding queued sprite register writes.
module sprite_cmd_fifo
  import sprite_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  sprite_cmd_t   din,
  output sprite_cmd_t   dout,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  sprite_cmd_t   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          push_s;
  logic          pop_s;

  // Flush discards both the incoming push and any pop in the same cycle
  assign push_s = push & (level_r != LW'(DEPTH)) & ~flush;
  assign pop_s  = pop & (level_r != {LW{1'b0}}) & ~flush;

  assign dout  = mem_r[rd_ptr_r];
  assign level = level_r;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1'b1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1'b1);
        2'b01:   level_r <= level_r - LW'(1'b1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/tqvp_sprite_update_sched.sv
// Replays buffered sprite writes to the engine only inside the vsync window,
// muxing direct writes onto the same port whenever no drain is running.
module tqvp_sprite_update_sched
  import sprite_sched_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              flush,
  input  logic              clr_flags,
  input  logic              irq_en,
  input  logic              vsync,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [ADDR_W-1:0] q_addr,
  input  logic [DATA_W-1:0] q_data,
  input  logic              dir_valid,
  output logic              dir_ready,
  input  logic [ADDR_W-1:0] dir_addr,
  input  logic [DATA_W-1:0] dir_data,
  output logic [ADDR_W-1:0] eng_address,
  output logic [DATA_W-1:0] eng_data,
  output logic [1:0]        eng_write_n,
  output logic [LW-1:0]     q_level,
  output logic              busy,
  output logic              done_flag,
  output logic              late_flag,
  output logic              irq
);

  sched_state_t      state_r;
  logic [LW-1:0]     remain_r;
  logic              vsync_q_r;
  logic [ADDR_W-1:0] eng_address_r;
  logic [DATA_W-1:0] eng_data_r;
  logic [1:0]        eng_write_n_r;
  logic              busy_r;
  logic              done_flag_r;
  logic              late_flag_r;

  logic [LW-1:0]     level_s;
  sprite_cmd_t       head_s;
  sprite_cmd_t       push_cmd_s;
  logic              push_s;
  logic              pop_s;
  logic              vsync_edge_s;
  logic              start_s;
  logic              dir_accept_s;

  assign vsync_edge_s = vsync & ~vsync_q_r;
  assign start_s      = vsync_edge_s & enable & (level_s != {LW{1'b0}});
  assign q_ready      = (level_s != LW'(DEPTH));
  assign dir_ready    = (state_r != DRAIN);
  assign dir_accept_s = dir_valid & dir_ready;
  assign push_s       = q_valid & q_ready;
  assign pop_s        = (state_r == DRAIN) & vsync & ~flush;
  assign push_cmd_s   = '{addr: q_addr, data: q_data};

  sprite_cmd_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush),
    .din   (push_cmd_s),
    .dout  (head_s),
    .level (level_s)
  );

  // Scheduler FSM, frame-edge tracking, sticky flags and the registered engine port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      remain_r      <= {LW{1'b0}};
      vsync_q_r     <= 1'b0;
      eng_address_r <= {ADDR_W{1'b0}};
      eng_data_r    <= {DATA_W{1'b0}};
      eng_write_n_r <= WR_NONE;
      busy_r        <= 1'b0;
      done_flag_r   <= 1'b0;
      late_flag_r   <= 1'b0;
    end else begin
      vsync_q_r     <= vsync;
      eng_write_n_r <= WR_NONE;
      // Clear first so a same-cycle set below takes precedence
      if (clr_flags) begin
        done_flag_r <= 1'b0;
        late_flag_r <= 1'b0;
      end
      if (dir_accept_s) begin
        eng_address_r <= dir_addr;
        eng_data_r    <= dir_data;
        eng_write_n_r <= WR_16;
      end
      if (flush) begin
        state_r  <= IDLE;
        busy_r   <= 1'b0;
        remain_r <= {LW{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            if (start_s) begin
              state_r  <= DRAIN;
              busy_r   <= 1'b1;
              remain_r <= level_s;
            end
          end
          DRAIN: begin
            if (!vsync) begin
              late_flag_r <= 1'b1;
              state_r     <= IDLE;
              busy_r      <= 1'b0;
            end else begin
              eng_address_r <= head_s.addr;
              eng_data_r    <= head_s.data;
              eng_write_n_r <= WR_16;
              remain_r      <= remain_r - LW'(1'b1);
              if (remain_r == LW'(1'b1)) begin
                state_r <= DONE;
                busy_r  <= 1'b0;
              end
            end
          end
          DONE: begin
            done_flag_r <= 1'b1;
            state_r     <= IDLE;
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign eng_address = eng_address_r;
  assign eng_data    = eng_data_r;
  assign eng_write_n = eng_write_n_r;
  assign q_level     = level_s;
  assign busy        = busy_r;
  assign done_flag   = done_flag_r;
  assign late_flag   = late_flag_r;
  assign irq         = done_flag_r & irq_en;

endmodule

// File: tb/tb_tqvp_sprite_update_sched.sv
// Directed-plus-random bench for the sprite update scheduler with a queue-based reference model.
module tb_tqvp_sprite_update_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, flush, clr_flags, irq_en, vsync;
  logic        q_valid, q_ready;
  logic [5:0]  q_addr;
  logic [15:0] q_data;
  logic        dir_valid, dir_ready;
  logic [5:0]  dir_addr;
  logic [15:0] dir_data;
  logic [5:0]  eng_address;
  logic [15:0] eng_data;
  logic [1:0]  eng_write_n;
  logic [3:0]  q_level;
  logic        busy, done_flag, late_flag, irq;

  int total = 0;
  int bad   = 0;

  logic [21:0] mdl_q[$];
  logic [21:0] act_q[$];

  always #5 clk = ~clk;

  tqvp_sprite_update_sched #(.DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush), .clr_flags(clr_flags),
    .irq_en(irq_en), .vsync(vsync), .q_valid(q_valid), .q_ready(q_ready),
    .q_addr(q_addr), .q_data(q_data), .dir_valid(dir_valid), .dir_ready(dir_ready),
    .dir_addr(dir_addr), .dir_data(dir_data), .eng_address(eng_address),
    .eng_data(eng_data), .eng_write_n(eng_write_n), .q_level(q_level), .busy(busy),
    .done_flag(done_flag), .late_flag(late_flag), .irq(irq)
  );

  // Record every engine write seen on the port
  always @(negedge clk) begin
    if (rst_n === 1'b1 && eng_write_n === 2'b01) act_q.push_back({eng_address, eng_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_one(input logic [5:0] a, input logic [15:0] d);
    q_valid = 1'b1;
    q_addr  = a;
    q_data  = d;
    if (q_ready === 1'b1) mdl_q.push_back({a, d});
    tick();
    q_valid = 1'b0;
  endtask

  task automatic push_rand();
    push_one(6'($urandom_range(0, 63)), 16'($urandom));
  endtask

  // The engine must have seen exactly the n oldest queued entries, in order
  task automatic expect_drain(input string tag, input int n);
    logic [21:0] e, a;
    chk({tag, "_count"}, act_q.size(), n);
    for (int i = 0; i < n; i++) begin
      e = (mdl_q.size() > 0) ? mdl_q.pop_front() : 22'h0;
      a = (act_q.size() > 0) ? act_q.pop_front() : 22'h3FFFFF;
      chk($sformatf("%s_w%0d", tag, i), a, e);
    end
    act_q.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wn"},    eng_write_n, 2'b11);
    chk({tag, "_addr"},  eng_address, 6'h00);
    chk({tag, "_data"},  eng_data, 16'h0000);
    chk({tag, "_done"},  done_flag, 1'b0);
    chk({tag, "_late"},  late_flag, 1'b0);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_irq"},   irq, 1'b0);
    chk({tag, "_qrdy"},  q_ready, 1'b1);
    chk({tag, "_drdy"},  dir_ready, 1'b1);
    chk({tag, "_level"}, q_level, 4'd0);
  endtask

  initial begin
    logic [5:0]  da;
    logic [15:0] dd;
    rst_n = 1'b0; enable = 1'b0; flush = 1'b0; clr_flags = 1'b0; irq_en = 1'b0; vsync = 1'b0;
    q_valid = 1'b0; q_addr = 6'h0; q_data = 16'h0;
    dir_valid = 1'b0; dir_addr = 6'h0; dir_data = 16'h0;
    #17;
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // Three known entries drained in order inside one window
    enable = 1'b1; irq_en = 1'b1;
    push_one(6'h04, 16'h1020);
    push_one(6'h06, 16'h00FF);
    push_one(6'h08, 16'hAA55);
    chk("t1_level", q_level, 4'd3);
    vsync = 1'b1;
    tick();
    chk("t1_busy", busy, 1'b1);
    chk("t1_idle_wn", eng_write_n, 2'b11);
    tick();
    chk("t1_w0_wn", eng_write_n, 2'b01);
    chk("t1_w0_addr", eng_address, 6'h04);
    chk("t1_w0_data", eng_data, 16'h1020);
    tick();
    chk("t1_w1_addr", eng_address, 6'h06);
    chk("t1_w1_data", eng_data, 16'h00FF);
    tick();
    chk("t1_w2_addr", eng_address, 6'h08);
    chk("t1_w2_data", eng_data, 16'hAA55);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_done_early", done_flag, 1'b0);
    tick();
    chk("t1_done", done_flag, 1'b1);
    chk("t1_irq", irq, 1'b1);
    chk("t1_wn_idle", eng_write_n, 2'b11);
    irq_en = 1'b0;
    #1;
    chk("t1_irq_gated", irq, 1'b0);
    irq_en = 1'b1;
    expect_drain("t1", 3);
    clr_flags = 1'b1; vsync = 1'b0;
    tick();
    clr_flags = 1'b0;
    chk("t1_clr", done_flag, 1'b0);

    // Window closes after two of five pops; the rest go next frame
    repeat (5) push_rand();
    vsync = 1'b1;
    tick();
    tick();
    tick();
    vsync = 1'b0;
    tick();
    chk("t2_late", late_flag, 1'b1);
    chk("t2_level", q_level, 4'd3);
    chk("t2_busy", busy, 1'b0);
    tick();
    expect_drain("t2a", 2);
    vsync = 1'b1;
    tick();
    chk("t2_busy2", busy, 1'b1);
    repeat (4) tick();
    chk("t2_done", done_flag, 1'b1);
    expect_drain("t2b", 3);
    chk("t2_level_end", q_level, 4'd0);
    vsync = 1'b0; clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;

    // Push during drain waits for the next frame; set beats clear
    repeat (2) push_rand();
    vsync = 1'b1;
    tick();
    push_rand();
    tick();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("t3_set_wins", done_flag, 1'b1);
    chk("t3_level", q_level, 4'd1);
    expect_drain("t3", 2);
    vsync = 1'b0; clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;

    // Direct write held off by a drain, issued in DONE
    vsync = 1'b1;
    tick();
    da = 6'($urandom_range(0, 63));
    dd = 16'($urandom);
    dir_valid = 1'b1; dir_addr = da; dir_data = dd;
    chk("t4_drdy_drain", dir_ready, 1'b0);
    tick();
    chk("t4_drdy_done", dir_ready, 1'b1);
    tick();
    chk("t4_dir_wn", eng_write_n, 2'b01);
    chk("t4_dir_addr", eng_address, da);
    chk("t4_dir_data", eng_data, dd);
    dir_valid = 1'b0;
    tick();
    chk("t4_wn_after", eng_write_n, 2'b11);
    mdl_q.push_back({da, dd});
    expect_drain("t4", 2);
    vsync = 1'b0;
    da = 6'($urandom_range(0, 63));
    dd = 16'($urandom);
    dir_valid = 1'b1; dir_addr = da; dir_data = dd;
    tick();
    dir_valid = 1'b0;
    chk("t4_idle_wn", eng_write_n, 2'b01);
    chk("t4_idle_addr", eng_address, da);
    chk("t4_idle_data", eng_data, dd);
    tick();
    chk("t4_hold_wn", eng_write_n, 2'b11);
    chk("t4_hold_data", eng_data, dd);
    act_q.delete();
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;

    // Full FIFO stalls, enable gates starts, flush aborts a drain
    repeat (8) push_rand();
    chk("t5_full_rdy", q_ready, 1'b0);
    chk("t5_full_level", q_level, 4'd8);
    push_rand();
    chk("t5_stall_level", q_level, 4'd8);
    chk("t5_mdl_size", mdl_q.size(), 8);
    enable = 1'b0; vsync = 1'b1;
    tick();
    chk("t5_enable_gate", busy, 1'b0);
    enable = 1'b1; vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    chk("t5_busy", busy, 1'b1);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_flush_level", q_level, 4'd0);
    chk("t5_flush_busy", busy, 1'b0);
    chk("t5_flush_wn", eng_write_n, 2'b11);
    chk("t5_flush_rdy", q_ready, 1'b1);
    repeat (4) tick();
    expect_drain("t5", 2);
    mdl_q.delete();

    // Asynchronous reset in the middle of a drain
    vsync = 1'b0;
    tick();
    repeat (4) push_rand();
    vsync = 1'b1;
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("t6");
    vsync = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_level_after", q_level, 4'd0);
    chk("t6_wn_after", eng_write_n, 2'b11);
    act_q.delete();
    mdl_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
